// File: rtl/ena_sync_debounce.sv
// Multi-channel synchroniser and tick-sampled debouncer for asynchronous enable/strap inputs.
// Each channel yields a clean level plus one-cycle rise/fall pulses on accepted transitions.
module ena_sync_debounce #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIV         = 1024,
  parameter int unsigned STABLE      = 3,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_RESET,
  input  logic [CH-1:0] i_in,
  output logic [CH-1:0] o_level,
  output logic [CH-1:0] o_rise,
  output logic [CH-1:0] o_fall,
  output logic          o_tick
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW = $clog2(STABLE + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

  logic [CH-1:0]         sync_q [SYNC_STAGES];
  logic [CH-1:0]         synced;
  logic [PW-1:0]         pre_q, pre_d;
  logic                  tick_q, tick_d;
  logic [CH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [CH-1:0]         level_q, level_d;
  logic [CH-1:0]         rise_q, rise_d;
  logic [CH-1:0]         fall_q, fall_d;

  // Plain flop chain per channel; nothing sits between stages.
  always_ff @(posedge i_clk) begin
    if (i_RESET) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {CH{RESET_LEVEL}};
      end
    end else begin
      sync_q[0] <= i_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Tick is registered from the next count so it is high exactly while the count sits at DIV-1.
  always_comb begin
    pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    tick_d = (pre_d == PRE_LAST);
  end

  // Debounce: a run of STABLE differing tick samples flips the level; any agreeing sample restarts it.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    if (tick_q) begin
      for (int unsigned c = 0; c < CH; c++) begin
        if (synced[c] == level_q[c]) begin
          cnt_d[c] = '0;
        end else if (cnt_q[c] == CNT_LAST) begin
          cnt_d[c]   = '0;
          level_d[c] = synced[c];
          rise_d[c]  = synced[c];
          fall_d[c]  = ~synced[c];
        end else begin
          cnt_d[c] = cnt_q[c] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_RESET) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= {CH{RESET_LEVEL}};
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
  assign o_tick  = tick_q;

endmodule

// File: tb/tb_ena_sync_debounce.sv
// Bench for ena_sync_debounce: two configurations checked every cycle against an edge-indexed
// behavioural model, plus directed scenarios with hand-computed expectations.
module tb_ena_sync_debounce;

  localparam int A_S = 2, A_DIV = 4, A_ST = 3;
  localparam logic A_RL = 1'b0;
  localparam int B_S = 3, B_DIV = 1, B_ST = 1;
  localparam logic B_RL = 1'b1;
  localparam int MAXE = 4096;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic [3:0] in_a, in_b;
  logic [3:0] o_level_a, o_rise_a, o_fall_a, o_level_b, o_rise_b, o_fall_b;
  logic o_tick_a, o_tick_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ena_sync_debounce #(.CH(4), .SYNC_STAGES(A_S), .DIV(A_DIV), .STABLE(A_ST), .RESET_LEVEL(A_RL)) u_dut_a (
    .i_clk(clk), .i_RESET(rst_a), .i_in(in_a),
    .o_level(o_level_a), .o_rise(o_rise_a), .o_fall(o_fall_a), .o_tick(o_tick_a));

  ena_sync_debounce #(.CH(4), .SYNC_STAGES(B_S), .DIV(B_DIV), .STABLE(B_ST), .RESET_LEVEL(B_RL)) u_dut_b (
    .i_clk(clk), .i_RESET(rst_b), .i_in(in_b),
    .o_level(o_level_b), .o_rise(o_rise_b), .o_fall(o_fall_b), .o_tick(o_tick_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model (indexed by absolute edge number) ----------------
  function automatic int p_s(int k);   return (k == 0) ? A_S : B_S;     endfunction
  function automatic int p_div(int k); return (k == 0) ? A_DIV : B_DIV; endfunction
  function automatic int p_st(int k);  return (k == 0) ? A_ST : B_ST;   endfunction
  function automatic logic p_rl(int k); return (k == 0) ? A_RL : B_RL;  endfunction

  logic [3:0] in_log [2][MAXE];
  int         e = 0;
  int         r_edge [2];
  int         run [2][4];
  logic [3:0] m_level [2];
  logic [3:0] m_rise [2];
  logic [3:0] m_fall [2];
  logic       m_tick [2];

  // Synced value after edge ed: the input sampled SYNC_STAGES-1 edges earlier, unless a reset intervened.
  function automatic logic [3:0] m_synced(int k, int ed);
    int src;
    src = ed - p_s(k) + 1;
    if (src > r_edge[k] && src >= 0 && src < MAXE) return in_log[k][src];
    return {4{p_rl(k)}};
  endfunction

  always @(posedge clk) begin
    logic [3:0] smp, inv;
    logic rs;
    e = e + 1;
    for (int k = 0; k < 2; k++) begin
      rs  = (k == 0) ? rst_a : rst_b;
      inv = (k == 0) ? in_a : in_b;
      smp = m_synced(k, e - 1);
      if (e < MAXE) in_log[k][e] = inv;
      m_rise[k] = '0;
      m_fall[k] = '0;
      if (rs) begin
        r_edge[k]  = e;
        m_level[k] = {4{p_rl(k)}};
        m_tick[k]  = 1'b0;
        for (int c = 0; c < 4; c++) run[k][c] = 0;
      end else begin
        if (m_tick[k]) begin
          for (int c = 0; c < 4; c++) begin
            if (smp[c] == m_level[k][c]) run[k][c] = 0;
            else begin
              run[k][c]++;
              if (run[k][c] == p_st(k)) begin
                m_level[k][c] = smp[c];
                if (smp[c]) m_rise[k][c] = 1'b1;
                else        m_fall[k][c] = 1'b1;
                run[k][c] = 0;
              end
            end
          end
        end
        m_tick[k] = ((e - r_edge[k]) % p_div(k)) == (p_div(k) - 1);
      end
    end
  end

  always @(negedge clk) begin
    if (e > 0) begin
      chk("a_level", 32'(o_level_a), 32'(m_level[0]));
      chk("a_rise",  32'(o_rise_a),  32'(m_rise[0]));
      chk("a_fall",  32'(o_fall_a),  32'(m_fall[0]));
      chk("a_tick",  32'(o_tick_a),  32'(m_tick[0]));
      chk("b_level", 32'(o_level_b), 32'(m_level[1]));
      chk("b_rise",  32'(o_rise_b),  32'(m_rise[1]));
      chk("b_fall",  32'(o_fall_b),  32'(m_fall[1]));
      chk("b_tick",  32'(o_tick_b),  32'(m_tick[1]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish by %0t", $time);
    $fatal(1, "timeout");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int first_tick, n_ticks, lat, nt, rise_n, fall_n;
    logic found, saw, tick_all;
    logic [3:0] pulses, lvl_or, rv, fv;

    rst_a = 1'b1; rst_b = 1'b1; in_a = 4'h0; in_b = 4'hF;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;

    // Reset/idle
    first_tick = -1; n_ticks = 0; pulses = '0; lvl_or = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (o_tick_a) begin
        n_ticks++;
        if (first_tick < 0) first_tick = i;
      end
      pulses |= (o_rise_a | o_fall_a);
      lvl_or |= o_level_a;
    end
    chk("idle_first_tick", 32'(first_tick), 32'd3);
    chk("idle_tick_count", 32'(n_ticks), 32'd10);
    chk("idle_quiet", 32'({lvl_or, pulses}), 32'd0);

    // Clean rise on channel 0
    in_a[0] = 1'b1;
    found = 1'b0; lat = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(negedge clk);
      if (o_level_a[0]) begin found = 1'b1; lat = i; end
    end
    chk("rise_seen", 32'(found), 32'd1);
    chk("rise_lat_window", 32'(lat >= 11 && lat <= 14), 32'd1);
    chk("rise_pulse", 32'({o_rise_a, o_fall_a}), 32'h10);
    chk("rise_others", 32'(o_level_a), 32'h1);
    @(negedge clk);
    chk("rise_pulse_clear", 32'(o_rise_a), 32'd0);
    repeat (10) @(negedge clk);

    // Glitch on channel 1: two tick samples rejected, three accepted
    for (int rep = 2; rep <= 3; rep++) begin
      in_a[1] = 1'b1;
      rise_n = 0; fall_n = 0; saw = 1'b0;
      for (int i = 1; i <= 4 * rep + 40; i++) begin
        @(negedge clk);
        if (i == 4 * rep) in_a[1] = 1'b0;
        rise_n += int'(o_rise_a[1]);
        fall_n += int'(o_fall_a[1]);
        saw |= o_level_a[1];
      end
      chk($sformatf("glitch%0d_rise", rep), 32'(rise_n), (rep == 3) ? 32'd1 : 32'd0);
      chk($sformatf("glitch%0d_fall", rep), 32'(fall_n), (rep == 3) ? 32'd1 : 32'd0);
      chk($sformatf("glitch%0d_level", rep), 32'(saw), (rep == 3) ? 32'd1 : 32'd0);
    end

    // Simultaneous multi-channel transitions
    in_a = 4'b0100;
    repeat (40) @(negedge clk);
    chk("multi_setup", 32'(o_level_a), 32'h4);
    in_a = 4'b1001;
    found = 1'b0; rv = '0; fv = '0;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(negedge clk);
      if ((o_rise_a | o_fall_a) != 4'h0) begin
        found = 1'b1; rv = o_rise_a; fv = o_fall_a;
      end
    end
    chk("multi_seen", 32'(found), 32'd1);
    chk("multi_rise", 32'(rv), 32'h9);
    chk("multi_fall", 32'(fv), 32'h4);
    @(negedge clk);
    chk("multi_level_hold", 32'(o_level_a), 32'h9);
    chk("multi_pulse_clear", 32'({o_rise_a, o_fall_a}), 32'd0);

    // Reset on the edge that would accept channel 2
    in_a = 4'h0;
    repeat (40) @(negedge clk);
    chk("rstmid_setup", 32'(o_level_a), 32'h0);
    in_a[2] = 1'b1;
    nt = 0;
    for (int i = 1; i <= 40 && nt < 3; i++) begin
      @(negedge clk);
      if (i >= 2 && o_tick_a) nt++;
    end
    chk("rstmid_ticks", 32'(nt), 32'd3);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("rstmid_level", 32'(o_level_a), 32'h0);
    chk("rstmid_pulse", 32'({o_rise_a, o_fall_a}), 32'd0);
    found = 1'b0; lat = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(negedge clk);
      if (o_level_a[2]) begin found = 1'b1; lat = i; end
    end
    chk("rstmid_requal_lat", 32'(lat), 32'd12);
    chk("rstmid_requal_rise", 32'(o_rise_a), 32'h4);

    // Second configuration: DIV=1, STABLE=1, SYNC_STAGES=3, RESET_LEVEL=1
    rst_b = 1'b0;
    tick_all = 1'b1; pulses = '0; lvl_or = 4'hF;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      tick_all &= o_tick_b;
      pulses |= (o_rise_b | o_fall_b);
      lvl_or &= o_level_b;
    end
    chk("b_tick_const", 32'(tick_all), 32'd1);
    chk("b_no_pulse", 32'(pulses), 32'd0);
    chk("b_level_idle", 32'(lvl_or), 32'hF);
    in_b[0] = 1'b0;
    found = 1'b0; lat = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (o_fall_b[0]) begin found = 1'b1; lat = i; end
    end
    chk("b_fall_lat", 32'(lat), 32'd4);
    chk("b_level_after", 32'(o_level_b), 32'hE);
    @(negedge clk);
    chk("b_fall_clear", 32'(o_fall_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ena_sync_debounce.md
Name: ena_sync_debounce

Overview:
- Multi-channel synchroniser and debouncer for asynchronous enable/control inputs, such as panel enable lines and mode straps, feeding the LED array controller core.
- Each channel passes through a parametrised synchroniser chain.
- The synchronised value is sampled on a shared prescaled tick and accepted only after STABLE consecutive agreeing samples.
- Each channel provides a clean level plus one-cycle rise/fall pulses.

Parameters:
- CH, 4, number of independent input channels (>=1)
- SYNC_STAGES, 2, synchroniser flop count per channel (>=2)
- DIV, 1024, sampling period in i_clk cycles (>=1; 1 = sample every cycle)
- STABLE, 3, consecutive differing samples required to accept a new level (>=1)
- RESET_LEVEL, 0, value loaded into all sync flops and o_level after reset

Ports:
- i_clk  input  1  system clock, all logic rising-edge
- i_RESET  input  1  synchronous, active-high reset
- i_in  input  CH  asynchronous raw inputs
- o_level  output  CH  debounced level per channel (registered)
- o_rise  output  CH  one-cycle pulse on accepted 0->1 transition
- o_fall  output  CH  one-cycle pulse on accepted 1->0 transition
- o_tick  output  1  sampling strobe (registered view of prescaler terminal count)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. i_RESET is sampled on the i_clk rising edge, has priority over all other logic, and takes effect fully in one edge.
- Reset values:
  - all sync flops = RESET_LEVEL; o_level = {CH{RESET_LEVEL}}
  - o_rise = 0, o_fall = 0, o_tick = 0
  - prescaler = 0; all stable counters = 0
- Synchroniser:
  - per channel shift chain, SYNC_STAGES deep; "synced" = last stage
  - no logic between stages
- Prescaler:
  - width max(1, clog2(DIV)); counts 0..DIV-1, then wraps to 0
  - o_tick = 1 exactly in the cycle where count == DIV-1
  - DIV=1: o_tick is constantly 1 after reset release
- Per-channel debounce:
  - stable counter width clog2(STABLE+1)
  - non-tick cycle: counter and o_level hold; o_rise/o_fall = 0
  - tick edge, synced == o_level: counter <= 0 (any agreeing sample restarts qualification)
  - tick edge, synced != o_level and counter+1 < STABLE: counter <= counter+1
  - tick edge, synced != o_level and counter+1 == STABLE: o_level <= synced, counter <= 0, and o_rise or o_fall <= 1 per direction
  - the pulse is visible in the same cycle o_level first shows its new value and lasts exactly one cycle
- Latency from a clean i_in step to o_level change, in edges:
  - min SYNC_STAGES+1+(STABLE-1)*DIV
  - max SYNC_STAGES+STABLE*DIV
- Channels are fully independent:
  - simultaneous transitions on several channels each produce their own pulses in the same cycle
  - o_rise and o_fall are never both set on one channel
- Boundary conditions:
  - glitch shorter than STABLE samples: no o_level change, no pulse
  - input equal to RESET_LEVEL after reset: no pulse
  - reset asserted mid-qualification: counters cleared; a pulse due on that edge is suppressed
  - STABLE=1: accepts on the first differing sample

Test Plan:
- Reset/idle:
  - setup: CH=4, SYNC_STAGES=2, DIV=4, STABLE=3, RESET_LEVEL=0, i_in=0
  - assert i_RESET 3 cycles, release, run 40 cycles
  - required: o_level=4'h0, o_rise=o_fall=0 throughout; o_tick high every 4th cycle, first at the 4th cycle after release
- Clean rise:
  - stimulus: i_in[0] 0->1 held
  - required: o_level[0]=1 after between 11 and 14 edges; o_rise[0]=1 for exactly that first cycle; o_fall=0; other channels unchanged
- Glitch reject:
  - stimulus: i_in[1] high long enough for 2 tick samples, then low
  - required: o_level[1] stays 0; no pulses. Repeat with 3 samples: o_level[1]=1 and one o_rise[1] pulse
- Simultaneous multi-channel:
  - setup: o_level=4'b0100
  - stimulus: i_in 4'b0100->4'b1001 in one cycle
  - required: on one cycle o_rise=4'b1001, o_fall=4'b0100; next cycle o_level=4'b1001 holds and pulses clear
- Reset mid-operation:
  - stimulus: i_in[2] rising, i_RESET asserted for 1 cycle after the 2nd qualifying tick
  - required: o_level[2]=0, no pulse on the reset edge; requalification needs 3 full new ticks
- Parameter sweep (DIV=1, STABLE=1, SYNC_STAGES=3, RESET_LEVEL=1):
  - required: o_tick constant 1 after release
  - required: an i_in[0] 1->0 step yields o_fall[0] exactly 4 edges later; no spurious pulse after reset with i_in all 1
